// File: rtl/sha1_pkg.sv
// rtl/sha1_pkg.sv - shared widths and FSM encoding for the SHA1 block feeder
package sha1_pkg;

    localparam int DBIT   = 512;
    localparam int WBIT   = 32;
    localparam int NWORDS = DBIT / WBIT;
    localparam int IDXW   = $clog2(NWORDS);
    localparam int CNTW   = 16;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NWORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_POP   = 2'd1,
        ST_LATCH = 2'd2,
        ST_SEND  = 2'd3
    } state_t;

endpackage

// File: rtl/sha1_word_mux.sv
// rtl/sha1_word_mux.sv - selects one 32-bit word of a 512-bit block, word 0 from the MSBs
module sha1_word_mux
    import sha1_pkg::*;
(
    input  logic [DBIT-1:0] i_blk,
    input  logic [IDXW-1:0] i_idx,
    output logic [WBIT-1:0] o_word
);

    always_comb begin
        o_word = '0;
        for (int k = 0; k < NWORDS; k++) begin
            if (i_idx == IDXW'(k)) begin
                o_word = i_blk[DBIT-1-WBIT*k -: WBIT];
            end
        end
    end

endmodule

// File: rtl/sha1_block_feeder.sv
// rtl/sha1_block_feeder.sv - pops 512-bit blocks from the RX FIFO and streams them as 16 words
module sha1_block_feeder
    import sha1_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            rx_empty,
    output logic            rd_uart,
    input  logic [DBIT-1:0] r_data,
    input  logic            msg_clear,
    output logic [WBIT-1:0] w_data,
    output logic            w_valid,
    input  logic            w_ready,
    output logic [IDXW-1:0] w_index,
    output logic            w_first_blk,
    output logic            w_last,
    output logic            blk_done,
    output logic [CNTW-1:0] blk_cnt,
    output logic            busy
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [DBIT-1:0] r_blk;
    logic [IDXW-1:0] r_idx;
    logic            r_first_pending;
    logic            r_first_blk;
    logic            r_blk_done;
    logic [CNTW-1:0] r_blk_cnt;
    logic            w_xfer;
    logic            w_blk_end;

    assign w_xfer    = (r_state == ST_SEND) && w_ready;
    assign w_blk_end = w_xfer && (r_idx == LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (!rx_empty) w_state_nxt = ST_POP;
            ST_POP:   w_state_nxt = ST_LATCH;
            ST_LATCH: w_state_nxt = ST_SEND;
            ST_SEND:  if (w_blk_end) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // first_pending is consumed when a block is latched, so a clear arriving
    // mid-block marks the following block rather than the one in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blk           <= '0;
            r_idx           <= '0;
            r_first_pending <= 1'b1;
            r_first_blk     <= 1'b0;
            r_blk_done      <= 1'b0;
            r_blk_cnt       <= '0;
        end else begin
            r_blk_done <= w_blk_end;
            if (r_state == ST_LATCH) begin
                r_blk       <= r_data;
                r_idx       <= '0;
                r_first_blk <= r_first_pending;
            end else if (w_xfer) begin
                r_idx <= r_idx + 1'b1;
            end
            if (msg_clear) begin
                r_first_pending <= 1'b1;
                r_blk_cnt       <= '0;
            end else begin
                if (r_state == ST_LATCH) r_first_pending <= 1'b0;
                if (w_blk_end)           r_blk_cnt       <= r_blk_cnt + 1'b1;
            end
        end
    end

    sha1_word_mux u_word_mux (
        .i_blk  (r_blk),
        .i_idx  (r_idx),
        .o_word (w_data)
    );

    assign rd_uart     = (r_state == ST_POP);
    assign w_valid     = (r_state == ST_SEND);
    assign busy        = (r_state != ST_IDLE);
    assign w_index     = r_idx;
    assign w_last      = (r_state == ST_SEND) && (r_idx == LAST_IDX);
    assign w_first_blk = r_first_blk;
    assign blk_done    = r_blk_done;
    assign blk_cnt     = r_blk_cnt;

endmodule
